// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the serial adder controller.
// Build option: SERIAL_ADDER_SUB_EN adds the op_sub input and subtract mode.
package serial_adder_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
// Build option: SERIAL_ADDER_SUB_EN adds the op_sub request bit.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             op_sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output op_sub,
`endif
    output start, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  op_sub,
`endif
    input  start, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// 1-bit full adder: the only arithmetic element of the serial datapath.
module serial_adder_ctrl_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one result bit per cycle, LSB first, through a single
// full adder. Latency is WIDTH+1 edges from the accepted start to the done pulse.
// Build option: SERIAL_ADDER_SUB_EN enables A-B (B inverted, carry preset to 1).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_adder_ctrl_if.slave io_bus
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic w_fa_b;
  logic w_fa_s;
  logic w_fa_co;
  logic w_carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;

  // Subtract is A + ~B + 1: invert B per bit and preset the carry.
  assign w_fa_b       = r_b[0] ^ r_sub;
  assign w_carry_init = io_bus.op_sub;
`else
  assign w_fa_b       = r_b[0];
  assign w_carry_init = 1'b0;
`endif

  serial_adder_ctrl_fa u_fa (
    .i_a  (r_a[0]),
    .i_b  (w_fa_b),
    .i_ci (r_carry),
    .o_s  (w_fa_s),
    .o_co (w_fa_co)
  );

  // FSM, operand/result shifters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_cnt   <= '0;
            r_carry <= w_carry_init;
            r_busy  <= 1'b1;
            r_state <= StRun;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= io_bus.op_sub;
`endif
          end
        end
        StRun: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_co;
          if (r_cnt == CntLast) begin
            // MSB step: r_carry is the carry into the MSB, w_fa_co the carry out.
            r_cnt   <= '0;
            r_cout  <= w_fa_co;
            r_ovf   <= r_carry ^ w_fa_co;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
  assign io_bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl (WIDTH=8): directed vectors with literal expectations plus
// a cycle-level reference model compared on every falling edge.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) ifc ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results from plain arithmetic, timing from the latency rules.
  bit             m_ready = 0;
  int             m_phase = -1;
  logic [W-1:0]   m_a, m_b;
  logic           m_sub;
  logic           m_busy, m_done, m_cout, m_ovf, m_valid;
  logic [W-1:0]   m_sum;

  initial begin
    logic [W:0] full;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ready = 1; m_phase = -1; m_busy = 0; m_done = 0;
        m_sum = '0; m_cout = 0; m_ovf = 0; m_valid = 1;
      end else if (m_ready) begin
        if (m_phase < 0) begin
          if (ifc.start) begin
            m_a = ifc.a; m_b = ifc.b;
`ifdef SERIAL_ADDER_SUB_EN
            m_sub = ifc.op_sub;
`else
            m_sub = 1'b0;
`endif
            m_phase = 0; m_busy = 1; m_valid = 0;
          end
        end else begin
          m_phase++;
          if (m_phase == W) begin
            if (m_sub) full = {1'b0, m_a} + {1'b0, ~m_b} + 9'd1;
            else       full = {1'b0, m_a} + {1'b0, m_b};
            m_sum  = full[W-1:0];
            m_cout = full[W];
            if (m_sub) m_ovf = (m_a[W-1] != m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
            else       m_ovf = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
            m_done = 1; m_valid = 1;
          end else if (m_phase == W + 1) begin
            m_done = 0; m_busy = 0; m_phase = -1;
          end
        end
      end
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("model busy", ifc.busy, m_busy);
        chk("model done", ifc.done, m_done);
        if (m_valid) begin
          chk("model sum", ifc.sum, m_sum);
          chk("model cout", ifc.cout, m_cout);
          chk("model ovf", ifc.ovf, m_ovf);
        end
      end
    end
  end

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    ifc.op_sub = s;
`endif
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int  n;
    bit  seen;
    @(posedge clk); #2;
    ifc.a = ta; ifc.b = tb_v; set_sub(ts); ifc.start = 1'b1;
    @(posedge clk); #2;
    ifc.start = 1'b0;
    ifc.a = 8'($urandom); ifc.b = 8'($urandom); set_sub(1'($urandom));
    n = 1; seen = 0;
    while (!seen && n <= 40) begin
      @(negedge clk);
      if (ifc.done) seen = 1;
      else n++;
    end
    chk({nm, " latency"}, n, 9);
    chk({nm, " sum"}, ifc.sum, es);
    chk({nm, " cout"}, ifc.cout, ec);
    chk({nm, " ovf"}, ifc.ovf, eo);
  endtask

  initial begin
    int ndone, gaps, nd;
    bit seen;
    int t[$];
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; set_sub(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", ifc.busy, 0);
    chk("reset done", ifc.done, 0);
    chk("reset sum", ifc.sum, 0);
    @(posedge clk); #2 rst = 1'b0;

    do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, "add 3c+05");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add ff+01");
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7f+01");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add 80+80");
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07");
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01");
`endif

    // Start pulse during RUN must be ignored.
    @(posedge clk); #2 ifc.a = 8'h10; ifc.b = 8'h20; set_sub(1'b0); ifc.start = 1'b1;
    @(posedge clk); #2 ifc.start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2 ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.start = 1'b1;
    @(posedge clk); #2 ifc.start = 1'b0;
    ndone = 0; gaps = 0; seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!seen && !ifc.busy) gaps++;
      if (ifc.done) begin
        ndone++; seen = 1;
        chk("ignored start sum", ifc.sum, 8'h30);
      end
    end
    chk("ignored start single done", ndone, 1);
    chk("ignored start busy gaps", gaps, 0);

    // Reset mid-RUN discards the operation.
    @(posedge clk); #2 ifc.a = 8'h55; ifc.b = 8'h11; ifc.start = 1'b1;
    @(posedge clk); #2 ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("mid-run rst busy", ifc.busy, 0);
    chk("mid-run rst sum", ifc.sum, 0);
    chk("mid-run rst done", ifc.done, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifc.done) nd++;
    end
    chk("mid-run rst no done", nd, 0);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after rst 01+02");

    // Reset wins over start on the same edge.
    @(posedge clk); #2 rst = 1'b1; ifc.start = 1'b1; ifc.a = 8'h0F; ifc.b = 8'h0F;
    @(posedge clk); #2 rst = 1'b0; ifc.start = 1'b0;
    @(negedge clk);
    chk("rst over start busy", ifc.busy, 0);
    repeat (12) @(posedge clk);

    // Start held high for 30 cycles: back-to-back operations every W+2 cycles.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      ifc.start = (i < 30);
      ifc.a = 8'($urandom); ifc.b = 8'($urandom);
      @(negedge clk);
      if (ifc.done) t.push_back(i);
    end
    chk("held start done count", t.size(), 3);
    if (t.size() == 3) begin
      chk("held start spacing 1", t[1] - t[0], 10);
      chk("held start spacing 2", t[2] - t[1], 10);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
